// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//   Shares one dual-port BRAM (separate read and write ports, 1-cycle
//   registered read) between two requesters: 0 = CPU data path,
//   1 = program loader / DMA. The read and write ports each have their own
//   round-robin arbiter, so one requester can read while the other writes
//   in the same cycle.
//
// Ports
//   clk, rst              single clock; synchronous active-high reset
//   req/we/addr/wdata{0,1} requests, held stable by the requester until gnt
//   gnt{0,1}              combinational grant (the op is accepted this cycle)
//   rvalid{0,1}, rdata    read return one cycle after the grant; rdata is shared
//   err{0,1}              1-cycle pulse after an out-of-range op was accepted
//   bram_*, b_ce_*        plain strobes to the BRAM; bram_out is its read data
// ---------------------------------------------------------------------------

// Two-requester round-robin arbiter for one class (read or write).
// The 'last' bit holds the index of the requester granted most recently.
// It resets to 1 so that requester 0 wins the first contention.
module bram_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (&req) gnt = last ? 2'b01 : 2'b10;
            else      gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       last <= 1'b1;
        else if (|gnt) last <= gnt[1];
    end
endmodule

module bram_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 24576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] bram_in,
    input  logic [DATA_W-1:0] bram_out,
    output logic [ADDR_W-1:0] bram_addr_r,
    output logic [ADDR_W-1:0] bram_addr_w,
    output logic              b_ce_w,
    output logic              b_ce_r
);
    localparam int NUM_REQ = 2;
    // One extra bit so that DEPTH can be represented even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } rq_t;

    rq_t [NUM_REQ-1:0] rq;
    logic [NUM_REQ-1:0] rd_req, wr_req, rd_gnt, wr_gnt, oor;

    assign rq[0] = '{req: req0, we: we0, addr: addr0, wdata: wdata0};
    assign rq[1] = '{req: req1, we: we1, addr: addr1, wdata: wdata1};

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign rd_req[i] = rq[i].req & ~rq[i].we;
        assign wr_req[i] = rq[i].req &  rq[i].we;
        assign oor[i]    = {1'b0, rq[i].addr} >= DEPTH_W;
    end

    bram_rr_arb u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .gnt(rd_gnt));
    bram_rr_arb u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .gnt(wr_gnt));

    // A requester is in only one class per cycle, so at most one of these is set.
    assign gnt0 = rd_gnt[0] | wr_gnt[0];
    assign gnt1 = rd_gnt[1] | wr_gnt[1];

    // Mux select defaults to requester 0 when idle, so the BRAM address and
    // data lines always carry addr0/wdata0 rather than floating.
    logic rd_sel, wr_sel;
    assign rd_sel = rd_gnt[1];
    assign wr_sel = wr_gnt[1];

    assign bram_addr_r = rq[rd_sel].addr;
    assign bram_addr_w = rq[wr_sel].addr;
    assign bram_in     = rq[wr_sel].wdata;

    // Out-of-range ops are still granted, but they never touch the BRAM.
    assign b_ce_r = |(rd_gnt & ~oor);
    assign b_ce_w = |(wr_gnt & ~oor);

    // Return stage. The read pipe is one stage deep to match the BRAM latency.
    logic [NUM_REQ-1:0] rd_vld_q;
    logic               rd_oor_q;
    logic [NUM_REQ-1:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= '0;
            rd_oor_q <= 1'b0;
            err_q    <= '0;
        end else begin
            rd_vld_q <= rd_gnt;
            rd_oor_q <= |(rd_gnt & oor);
            err_q    <= (rd_gnt | wr_gnt) & oor;
        end
    end

    // Returns are masked while rst is high. A read granted in the cycle just
    // before reset is therefore dropped, even though its flag is still set.
    assign rvalid0 = rd_vld_q[0] & ~rst;
    assign rvalid1 = rd_vld_q[1] & ~rst;
    assign err0    = err_q[0] & ~rst;
    assign err1    = err_q[1] & ~rst;
    assign rdata   = (|rd_vld_q && !rd_oor_q && !rst) ? bram_out : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter. A behavioural 24576x16 BRAM with a
// registered read port sits behind the DUT. Inputs change just after the
// falling edge, and outputs are sampled 1 ns later.
module tb_bram_port_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 24576;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [DATA_W-1:0] rdata, bram_in, bram_out;
    logic [ADDR_W-1:0] bram_addr_r, bram_addr_w;
    logic              b_ce_w, b_ce_r;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err0(err0), .err1(err1),
        .bram_in(bram_in), .bram_out(bram_out),
        .bram_addr_r(bram_addr_r), .bram_addr_w(bram_addr_w),
        .b_ce_w(b_ce_w), .b_ce_r(b_ce_r)
    );

    // BRAM model. Nonblocking updates give read-before-write on the same address.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (b_ce_r) bram_out <= mem[bram_addr_r];
        if (b_ce_w) mem[bram_addr_w] <= bram_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Holds rst for two cycles with a request pending, then releases it
    // just after a falling edge.
    task automatic do_reset();
        tick(); rst = 1; idle(); req0 = 1; addr0 = 15'h0010;
        #1;
        chk("rst_gnt0",  32'(gnt0), 0);
        chk("rst_ce_r",  32'(b_ce_r), 0);
        tick(); idle();
        #1;
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_err0",    32'(err0), 0);
        chk("rst_rdata",   32'(rdata), 0);
        tick(); rst = 0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0040] = 16'hAAAA;
        bram_out = '0;
        rst = 1; idle();

        // 1: single read, latency 1
        do_reset();
        req0 = 1; addr0 = 15'h0010;
        #1;
        chk("t1_gnt0", 32'(gnt0), 1);
        chk("t1_ce_r", 32'(b_ce_r), 1);
        chk("t1_addr_r", 32'(bram_addr_r), 32'h0010);
        tick(); idle();
        #1;
        chk("t1_rvalid0", 32'(rvalid0), 1);
        chk("t1_rvalid1", 32'(rvalid1), 0);
        chk("t1_rdata", 32'(rdata), 32'hBEEF);

        // 2: write contention, then readback
        do_reset();
        req0 = 1; we0 = 1; addr0 = 15'h0100; wdata0 = 16'h1234;
        req1 = 1; we1 = 1; addr1 = 15'h0200; wdata1 = 16'h5678;
        #1;
        chk("t2_c0_gnt0", 32'(gnt0), 1);
        chk("t2_c0_gnt1", 32'(gnt1), 0);
        chk("t2_c0_ce_w", 32'(b_ce_w), 1);
        chk("t2_c0_addr_w", 32'(bram_addr_w), 32'h0100);
        chk("t2_c0_in", 32'(bram_in), 32'h1234);
        tick(); req0 = 0; we0 = 0;
        #1;
        chk("t2_c1_gnt1", 32'(gnt1), 1);
        chk("t2_c1_addr_w", 32'(bram_addr_w), 32'h0200);
        chk("t2_c1_in", 32'(bram_in), 32'h5678);
        tick(); idle(); req0 = 1; addr0 = 15'h0100;
        tick(); addr0 = 15'h0200;
        #1;
        chk("t2_rb0", 32'(rdata), 32'h1234);
        tick(); idle();
        #1;
        chk("t2_rb1", 32'(rdata), 32'h5678);
        chk("t2_rb1_v", 32'(rvalid0), 1);

        // 3: continuous read contention alternates, one return per cycle
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                req0 = 1; addr0 = 15'h0010;
                req1 = 1; addr1 = 15'h0040;
            end else idle();
            #1;
            if (k < 6) begin
                chk($sformatf("t3_gnt0_%0d", k), 32'(gnt0), 32'((k % 2) == 0));
                chk($sformatf("t3_gnt1_%0d", k), 32'(gnt1), 32'((k % 2) == 1));
            end
            if (k > 0) begin
                chk($sformatf("t3_rv0_%0d", k), 32'(rvalid0), 32'(((k-1) % 2) == 0));
                chk($sformatf("t3_rv1_%0d", k), 32'(rvalid1), 32'(((k-1) % 2) == 1));
                chk($sformatf("t3_rd_%0d", k), 32'(rdata), ((k-1) % 2) == 0 ? 32'hBEEF : 32'hAAAA);
            end
            tick();
        end

        // 4: same-address read and write, read-before-write
        do_reset();
        req0 = 1; addr0 = 15'h0040;
        req1 = 1; we1 = 1; addr1 = 15'h0040; wdata1 = 16'h5555;
        #1;
        chk("t4_gnt0", 32'(gnt0), 1);
        chk("t4_gnt1", 32'(gnt1), 1);
        tick(); idle(); req0 = 1; addr0 = 15'h0040;
        #1;
        chk("t4_old", 32'(rdata), 32'hAAAA);
        tick(); idle();
        #1;
        chk("t4_new", 32'(rdata), 32'h5555);

        // 5: out-of-range read and write
        do_reset();
        req1 = 1; addr1 = 15'(DEPTH);
        req0 = 1; we0 = 1; addr0 = 15'h7FFF; wdata0 = 16'h9999;
        #1;
        chk("t5_gnt0", 32'(gnt0), 1);
        chk("t5_gnt1", 32'(gnt1), 1);
        chk("t5_ce_r", 32'(b_ce_r), 0);
        chk("t5_ce_w", 32'(b_ce_w), 0);
        tick(); idle(); req0 = 1; addr0 = 15'(DEPTH - 1);
        #1;
        chk("t5_err1", 32'(err1), 1);
        chk("t5_rv1", 32'(rvalid1), 1);
        chk("t5_rd0", 32'(rdata), 0);
        chk("t5_err0", 32'(err0), 1);
        chk("t5_rv0", 32'(rvalid0), 0);
        chk("t5_last_ce_r", 32'(b_ce_r), 1);
        tick(); idle();
        #1;
        chk("t5_err0_pulse", 32'(err0), 0);
        chk("t5_err1_pulse", 32'(err1), 0);
        chk("t5_last_rv0", 32'(rvalid0), 1);

        // 6: reset right after a read grant
        do_reset();
        req0 = 1; addr0 = 15'h0010;
        #1;
        chk("t6_gnt0", 32'(gnt0), 1);
        tick(); idle(); rst = 1;
        #1;
        chk("t6_rv0_rst", 32'(rvalid0), 0);
        tick(); rst = 0;
        req0 = 1; addr0 = 15'h0010;
        req1 = 1; addr1 = 15'h0040;
        #1;
        chk("t6_rv0_post", 32'(rvalid0), 0);
        chk("t6_gnt0_prio", 32'(gnt0), 1);
        chk("t6_gnt1_prio", 32'(gnt1), 0);
        tick(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
